pipe_skid_stage: RTL

Parametrised inter-stage pipeline register for the ARM core pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries a packed control/data payload from stage N to stage N+1 with a valid/ready handshake. A two-entry skid buffer keeps throughput at one transfer per cycle under back-pressure. It replaces the fixed-field, freeze/flush-only stage registers: each instance is sized by parameter and has synchronous flush.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_sat_cnt.sv | 41 ++++
 rtl/pipe_skid_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the inter-stage pipeline registers of the ARM core:
//   - pipe_state_e : occupancy state of a skid stage (EMPTY, ONE, FULL)
//   - *_W          : payload width of each stage boundary, used as DATA_W
//   - entry_count  : number of valid entries held in a given state
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        ONE   = 2'd1,   // main holds a payload, skid free
        FULL  = 2'd2    // main and skid both hold payloads
    } pipe_state_e;

    // Payload widths per stage boundary (control + PC + operands + tags).
    localparam int IF_ID_W   = 64;
    localparam int ID_EXE_W  = 160;
    localparam int EXE_MEM_W = 128;
    localparam int MEM_WB_W  = 80;

    // Valid entries held in a state; this is what a flush discards.
    function automatic logic [1:0] entry_count(input pipe_state_e state);
        case (state)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_sat_cnt
// Saturating accumulator: adds 0, 1 or 2 per clock and sticks at all-ones.
// Ports:
//   clk   in         clock
//   clear in         synchronous clear (wins over inc)
//   inc   in  [1:0]  amount to add this cycle
//   count out [CNT_W-1:0] accumulated value
// -----------------------------------------------------------------------------
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    // One extra bit holds the carry; count + 2 can overflow by at most 2,
    // so a set carry always means "clamp to the maximum".
    logic [CNT_W:0] sum;

    // NOTE: combinational blocks assign every output on every path so no
    // latch is inferred; here the single assignment covers all cases.
    always_comb begin
        sum = {1'b0, count} + {{(CNT_W - 1){1'b0}}, inc};
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (sum[CNT_W]) begin
            count <= '1;
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Inter-stage pipeline register with valid/ready handshake and a two-entry
// skid buffer (main + skid), sustaining one transfer per cycle under
// back-pressure. Synchronous flush squashes the stage contents.
//
// Optional feature: define PIPE_STAGE_STATS_EN to build the stall and drop
// statistics counters; otherwise stall_cnt and drop_cnt are constant 0.
//
// Ports:
//   clk       in               clock, rising edge
//   rst       in               synchronous active-high reset (beats flush)
//   flush     in               synchronous squash of held entries
//   in_valid  in               upstream has a payload
//   in_ready  out              stage can accept (skid entry empty)
//   in_data   in  [DATA_W-1:0] upstream payload
//   out_valid out              payload available downstream
//   out_ready in               downstream accepts (low = stall)
//   out_data  out [DATA_W-1:0] payload, all-zero when out_valid=0
//   stall_cnt out [CNT_W-1:0]  saturating count of stalled cycles
//   drop_cnt  out [CNT_W-1:0]  saturating count of entries discarded by flush
// -----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::ID_EXE_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    pipe_state_e       state;
    logic [DATA_W-1:0] main_q;   // older entry, drives out_data
    logic [DATA_W-1:0] skid_q;   // younger entry, filled only under stall

    // Handshake outputs decode the state flop directly, so neither depends
    // combinationally on in_valid or out_ready.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign out_data  = main_q;

    // NOTE: the payload registers are reset/flushed along with the state
    // because out_data must read all-zero whenever the stage is empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        main_q <= in_data;
                    end else if (in_valid) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (out_ready) begin
                        main_q <= '0;
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so in_valid is ignored.
                    if (out_ready) begin
                        main_q <= skid_q;
                        skid_q <= '0;
                        state  <= ONE;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [1:0] stall_inc;
    logic [1:0] drop_inc;

    // A flush cycle still counts as stalled if the output is being held.
    assign stall_inc = {1'b0, out_valid & ~out_ready};
    // Reset clears the counter, so the drop amount there is irrelevant.
    assign drop_inc  = flush ? entry_count(state) : 2'd0;

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (drop_inc),
        .count (drop_cnt)
    );
`else
    assign stall_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule
